// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding and opcode classes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

    // Opcode classes; every other encoding is an ALU operation.
    localparam logic [2:0] OP_BR   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_LD   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Loads and stores are the only instructions that visit MEM.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/cpu_sequencer_watchdog.sv
// Watchdog counter bounding how long the sequencer waits in MEM for a data memory ack.
// Latency: expired is combinational from the count; count advances one per enabled cycle.
// Backpressure: none; the sequencer holds clear while outside MEM and enables while unacked.
module seq_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Final wait cycle index: MEM_TIMEOUT cycles in MEM means the count reaches MEM_TIMEOUT-1.
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    // Count unacknowledged MEM cycles; held at zero outside MEM, never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM stepping each instruction through FETCH/DECODE/EXEC/MEM/WB for the 8-bit core.
// Latency: ALU 4 cycles, BR 3, ST 4+wait, LD 5+wait; retired count updates the cycle after pc_en/pc_load.
// Backpressure: MEM holds mem_req until mem_ack; watchdog forces an error halt after MEM_TIMEOUT cycles.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned PC_BITS     = 9,
    parameter int unsigned CNT_BITS    = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          instr_op,
    input  logic                branch_taken,
    input  logic                mem_ack,
    output logic                ir_load,
    output logic                pc_en,
    output logic                pc_load,
    output logic                reg_write,
    output logic                mem_req,
    output logic                mem_we,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [CNT_BITS-1:0] retired
);

    // PC width only qualifies retire bookkeeping; a degenerate PC disables it.
    localparam logic PC_OK = (PC_BITS > 0);

    seq_state_t state, state_nxt;
    logic [2:0] op_q;
    logic       wd_en;
    logic       wd_expired;
    logic       err_set;
    logic       retire;

    seq_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != MEM),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // State register and opcode latch; op_q only changes on the FETCH edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                op_q <= instr_op;
            end
        end
    end

    // Next-state and per-state outputs; only pc_en/pc_load depend on inputs.
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_load   = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        wd_en     = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                ir_load   = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                busy      = 1'b1;
                state_nxt = (op_q == OP_HALT) ? HALT : EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (op_q == OP_BR) begin
                    pc_load   = branch_taken;
                    pc_en     = !branch_taken;
                    state_nxt = FETCH;
                end else if (is_mem_op(op_q)) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = (op_q == OP_ST);
                if (mem_ack) begin
                    if (op_q == OP_ST) begin
                        pc_en     = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_expired) begin
                        err_set   = 1'b1;
                        state_nxt = HALT;
                    end
                end
            end
            WB: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                pc_en     = 1'b1;
                state_nxt = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign retire = (pc_en || pc_load) && PC_OK;

    // Sticky watchdog error and saturating retired-instruction counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            error   <= 1'b0;
            retired <= '0;
        end else begin
            if (err_set) begin
                error <= 1'b1;
            end
            if (retire && (retired != {CNT_BITS{1'b1}})) begin
                retired <= retired + 1'b1;
            end
        end
    end

endmodule
